// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory user-port arbiter and its picker.
package mem_arb_pkg;

    localparam int MEM_ADDR_W = 26;
    localparam int MEM_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        ISSUE       = 2'd1,
        WAIT_ACCEPT = 2'd2,
        WAIT_DONE   = 2'd3
    } arb_state_t;

    typedef enum logic {
        OP_WRITE = 1'b0,
        OP_READ  = 1'b1
    } arb_op_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester after last_idx (wrapping) wins.
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_idx,
    output logic [N-1:0]  grant_oh,
    output logic [IW-1:0] grant_idx,
    output logic          any_req
);

    logic [IW:0] cand;

    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        any_req   = |req;
        cand      = '0;
        // Scan from the farthest candidate inwards so the nearest one after last_idx wins.
        for (int off = N; off >= 1; off--) begin
            cand = {1'b0, last_idx} + (IW+1)'(off);
            if (cand >= (IW+1)'(N)) begin
                cand = cand - (IW+1)'(N);
            end
            if (req[cand[IW-1:0]]) begin
                grant_oh                 = '0;
                grant_oh[cand[IW-1:0]]   = 1'b1;
                grant_idx                = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing the single-word memory user port between NUM_REQ requesters,
// with an accept watchdog that aborts transactions the memory never picks up.
module memory_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_W         = MEM_ADDR_W,
    parameter int DATA_W         = MEM_DATA_W,
    parameter int ACCEPT_TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ-1:0]        req_read,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_done,
    output logic                      req_error,
    output logic [DATA_W-1:0]         rdata,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      mem_write_req,
    output logic                      mem_read_req,
    output logic [DATA_W-1:0]         mem_data_write,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic [DATA_W-1:0]         mem_data_read,
    input  logic                      mem_busy
);

    localparam int IW = idx_w(NUM_REQ);

    arb_state_t         state;
    arb_state_t         state_nxt;
    arb_op_t            op;
    logic [IW-1:0]      last_idx;
    logic [15:0]        timer;
    logic [NUM_REQ-1:0] req_any;
    logic [NUM_REQ-1:0] pick_oh;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;
    logic               do_grant;
    logic               do_finish;
    logic               do_abort;

    assign req_any = req_write | req_read;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .req       (req_any),
        .last_idx  (last_idx),
        .grant_oh  (pick_oh),
        .grant_idx (pick_idx),
        .any_req   (pick_any)
    );

    assign mem_write_req = (state == ISSUE) && (op == OP_WRITE);
    assign mem_read_req  = (state == ISSUE) && (op == OP_READ);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        do_grant  = 1'b0;
        do_finish = 1'b0;
        do_abort  = 1'b0;
        case (state)
            IDLE: begin
                // No arbitration in the done cycle: the finished requester still holds its level.
                if (!mem_busy && pick_any && (req_done == '0)) begin
                    do_grant  = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = WAIT_ACCEPT;
            end
            WAIT_ACCEPT: begin
                if (mem_busy) begin
                    state_nxt = WAIT_DONE;
                end else if (timer == 16'(ACCEPT_TIMEOUT - 1)) begin
                    do_abort  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!mem_busy) begin
                    do_finish = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant          <= '0;
            last_idx       <= IW'(NUM_REQ - 1);
            op             <= OP_WRITE;
            timer          <= '0;
            mem_addr       <= '0;
            mem_data_write <= '0;
            req_done       <= '0;
            req_error      <= 1'b0;
            rdata          <= '0;
        end else begin
            req_done  <= '0;
            req_error <= 1'b0;
            // Address and data are captured once at grant and held until the next grant.
            if (do_grant) begin
                grant          <= pick_oh;
                last_idx       <= pick_idx;
                mem_addr       <= req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                mem_data_write <= req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
                op             <= req_write[pick_idx] ? OP_WRITE : OP_READ;
            end
            if (state == ISSUE) begin
                timer <= '0;
            end else if ((state == WAIT_ACCEPT) && !mem_busy) begin
                timer <= timer + 16'd1;
            end
            if (do_finish || do_abort) begin
                req_done  <= grant;
                req_error <= do_abort;
                grant     <= '0;
            end
            if (do_finish && (op == OP_READ)) begin
                rdata <= mem_data_read;
            end
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: behavioural memory port model plus hand-computed expectations.
`timescale 1ns/1ps
module tb_memory_arbiter;

    localparam int NR  = 2;
    localparam int AW  = 26;
    localparam int DW  = 32;
    localparam int TMO = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_write;
    logic [NR-1:0]     req_read;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR-1:0]     req_done;
    logic              req_error;
    logic [DW-1:0]     rdata;
    logic [NR-1:0]     grant;
    logic              mem_write_req;
    logic              mem_read_req;
    logic [DW-1:0]     mem_data_write;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_data_read;
    logic              mem_busy;

    memory_arbiter #(
        .NUM_REQ        (NR),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .ACCEPT_TIMEOUT (TMO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_write      (req_write),
        .req_read       (req_read),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_done       (req_done),
        .req_error      (req_error),
        .rdata          (rdata),
        .grant          (grant),
        .mem_write_req  (mem_write_req),
        .mem_read_req   (mem_read_req),
        .mem_data_write (mem_data_write),
        .mem_addr       (mem_addr),
        .mem_data_read  (mem_data_read),
        .mem_busy       (mem_busy)
    );

    always #5 clk = ~clk;

    // Memory model controls
    int        busy_len;
    int        busy_cnt;
    int        issue_cnt;
    bit        model_dead;
    bit        force_busy;
    bit        model_flush;
    logic [DW-1:0] model_rdata;

    initial begin
        busy_cnt      = 0;
        issue_cnt     = 0;
        mem_busy      = 1'b0;
        mem_data_read = '0;
        forever begin
            @(negedge clk);
            if (model_flush) begin
                busy_cnt = 0;
                mem_busy = 1'b0;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    mem_busy      = force_busy;
                    mem_data_read = model_rdata;
                end
            end else if (!model_dead && (mem_write_req || mem_read_req)) begin
                issue_cnt++;
                mem_busy = 1'b1;
                busy_cnt = busy_len;
            end else begin
                mem_busy = force_busy;
            end
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic          iss_wr;
    logic          iss_rd;
    logic [AW-1:0] iss_addr;
    logic [DW-1:0] iss_wdata;
    logic [NR-1:0] iss_grant;
    logic [NR-1:0] dn_vec;
    logic          dn_err;
    logic [DW-1:0] dn_rdata;

    task automatic wait_issue(input string tag, output int cyc);
        bit seen;
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (mem_write_req || mem_read_req) begin
                seen      = 1'b1;
                iss_wr    = mem_write_req;
                iss_rd    = mem_read_req;
                iss_addr  = mem_addr;
                iss_wdata = mem_data_write;
                iss_grant = grant;
            end
        end
        chk({tag, "_issue_seen"}, 64'(seen), 64'd1);
    endtask

    task automatic wait_done(input string tag, output int cyc);
        bit seen;
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (req_done != '0) begin
                seen     = 1'b1;
                dn_vec   = req_done;
                dn_err   = req_error;
                dn_rdata = rdata;
            end
        end
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    endtask

    initial begin
        int cyc;
        int n0;
        int cnt;
        logic [NR-1:0] exp_vec;

        busy_len    = 3;
        model_dead  = 1'b0;
        force_busy  = 1'b0;
        model_flush = 1'b0;
        model_rdata = '0;
        req_write   = '0;
        req_read    = '0;
        req_addr    = '0;
        req_wdata   = '0;
        reset       = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_grant", grant, 0);
        chk("rst_done", req_done, 0);
        chk("rst_wreq", mem_write_req, 0);
        chk("rst_rreq", mem_read_req, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_rdata", rdata, 0);
        reset = 1'b0;
        @(negedge clk);

        // Single write from requester 0
        req_addr[0 +: AW]  = 26'h000010;
        req_wdata[0 +: DW] = 32'hDEADBEEF;
        req_write[0]       = 1'b1;
        n0 = issue_cnt;
        wait_issue("wr", cyc);
        chk("wr_iss_wreq", iss_wr, 1);
        chk("wr_iss_rreq", iss_rd, 0);
        chk("wr_iss_addr", iss_addr, 26'h000010);
        chk("wr_iss_data", iss_wdata, 32'hDEADBEEF);
        chk("wr_iss_grant", iss_grant, 2'b01);
        wait_done("wr", cyc);
        req_write[0] = 1'b0;
        chk("wr_latency", cyc, 4);
        chk("wr_done_vec", dn_vec, 2'b01);
        chk("wr_done_err", dn_err, 0);
        @(negedge clk);
        chk("wr_pulse_end", req_done, 0);
        chk("wr_grant_idle", grant, 0);
        chk("wr_one_issue", issue_cnt - n0, 1);

        // Read from requester 1
        model_rdata        = 32'h12345678;
        req_addr[AW +: AW] = 26'h0000AB;
        req_read[1]        = 1'b1;
        wait_issue("rd", cyc);
        chk("rd_iss_rreq", iss_rd, 1);
        chk("rd_iss_wreq", iss_wr, 0);
        chk("rd_iss_addr", iss_addr, 26'h0000AB);
        chk("rd_iss_grant", iss_grant, 2'b10);
        wait_done("rd", cyc);
        req_read[1] = 1'b0;
        chk("rd_done_vec", dn_vec, 2'b10);
        chk("rd_data", dn_rdata, 32'h12345678);
        chk("rd_done_err", dn_err, 0);
        model_rdata = 32'hCAFEF00D;
        repeat (3) @(negedge clk);
        chk("rd_hold", rdata, 32'h12345678);

        // Write and read on the same requester: only the write happens
        req_addr[0 +: AW]  = 26'h000020;
        req_wdata[0 +: DW] = 32'h000055AA;
        req_write[0]       = 1'b1;
        req_read[0]        = 1'b1;
        n0 = issue_cnt;
        wait_issue("wrrd", cyc);
        chk("wrrd_iss_wreq", iss_wr, 1);
        chk("wrrd_iss_rreq", iss_rd, 0);
        wait_done("wrrd", cyc);
        req_write[0] = 1'b0;
        req_read[0]  = 1'b0;
        chk("wrrd_done_vec", dn_vec, 2'b01);
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (req_done != '0) cnt++;
        end
        chk("wrrd_extra_done", cnt, 0);
        chk("wrrd_one_issue", issue_cnt - n0, 1);
        chk("wrrd_rdata_kept", rdata, 32'h12345678);

        // Memory busy while idle: no issue until it drops
        force_busy = 1'b1;
        repeat (2) @(negedge clk);
        req_addr[0 +: AW] = 26'h000030;
        req_write[0]      = 1'b1;
        cnt = 0;
        repeat (50) begin
            @(negedge clk);
            if (mem_write_req || mem_read_req) cnt++;
        end
        chk("busy_no_issue", cnt, 0);
        force_busy = 1'b0;
        wait_issue("busy", cyc);
        chk("busy_iss_addr", iss_addr, 26'h000030);
        wait_done("busy", cyc);
        req_write[0] = 1'b0;
        chk("busy_done_vec", dn_vec, 2'b01);
        chk("busy_done_err", dn_err, 0);

        // Accept timeout: memory never raises busy
        model_dead        = 1'b1;
        req_addr[0 +: AW] = 26'h000040;
        req_write[0]      = 1'b1;
        wait_issue("tmo", cyc);
        wait_done("tmo", cyc);
        req_write[0] = 1'b0;
        chk("tmo_latency", cyc, TMO + 1);
        chk("tmo_done_vec", dn_vec, 2'b01);
        chk("tmo_err", dn_err, 1);
        chk("tmo_rdata_kept", dn_rdata, 32'h12345678);
        @(negedge clk);
        chk("tmo_pulse_end", req_done, 0);
        model_dead = 1'b0;
        req_addr[AW +: AW]  = 26'h000050;
        req_wdata[DW +: DW] = 32'hA5A5A5A5;
        req_write[1]        = 1'b1;
        wait_issue("post_tmo", cyc);
        chk("post_tmo_addr", iss_addr, 26'h000050);
        chk("post_tmo_data", iss_wdata, 32'hA5A5A5A5);
        wait_done("post_tmo", cyc);
        req_write[1] = 1'b0;
        chk("post_tmo_vec", dn_vec, 2'b10);
        chk("post_tmo_err", dn_err, 0);

        // Contention: both requesters write continuously, grants alternate from 0
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        req_addr[0 +: AW]  = 26'h000100;
        req_addr[AW +: AW] = 26'h000200;
        req_write          = 2'b11;
        for (int i = 0; i < 6; i++) begin
            exp_vec = (i % 2 == 0) ? 2'b01 : 2'b10;
            wait_issue($sformatf("cont%0d", i), cyc);
            chk($sformatf("cont%0d_addr", i), iss_addr, (i % 2 == 0) ? 26'h000100 : 26'h000200);
            wait_done($sformatf("cont%0d", i), cyc);
            chk($sformatf("cont%0d_order", i), dn_vec, exp_vec);
        end
        req_write = '0;
        repeat (3) @(negedge clk);

        // Reset during WAIT_DONE
        busy_len            = 20;
        req_addr[AW +: AW]  = 26'h000300;
        req_wdata[DW +: DW] = 32'h00000077;
        req_write[1]        = 1'b1;
        wait_issue("rstm", cyc);
        repeat (3) @(negedge clk);
        chk("rstm_pre_grant", grant, 2'b10);
        #2;
        reset = 1'b1;
        #1;
        chk("rstm_grant", grant, 0);
        chk("rstm_addr", mem_addr, 0);
        chk("rstm_wdata", mem_data_write, 0);
        chk("rstm_wreq", mem_write_req, 0);
        chk("rstm_done", req_done, 0);
        model_flush  = 1'b1;
        req_write[1] = 1'b0;
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (req_done != '0) cnt++;
        end
        chk("rstm_no_done", cnt, 0);
        model_flush = 1'b0;
        busy_len    = 3;
        reset       = 1'b0;
        @(negedge clk);
        req_addr[0 +: AW] = 26'h000400;
        req_write         = 2'b11;
        wait_issue("rstm_after", cyc);
        chk("rstm_after_grant", iss_grant, 2'b01);
        chk("rstm_after_addr", iss_addr, 26'h000400);
        wait_done("rstm_after", cyc);
        req_write = '0;
        chk("rstm_after_vec", dn_vec, 2'b01);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
Round-robin arbiter that shares the single memory user port (write_req/read_req/data_write/data_read/addr/busy) between NUM_REQ requesters, e.g. the DAQ event writer and the readout path. It serialises single-word transactions, holds address and data stable for the memory block, and returns a per-requester completion pulse with captured read data. A watchdog terminates a transaction if the memory never accepts it.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_W, 26, memory word address width
DATA_W, 32, memory data width
ACCEPT_TIMEOUT, 255, cycles to wait for busy to rise after issue before aborting (1..65535)

Ports:
clk  in  1  system clock (phy_clk domain of the memory block)
reset  in  1  asynchronous, active-high reset
req_write  in  NUM_REQ  per-requester write request, level, held until req_done
req_read  in  NUM_REQ  per-requester read request, level, held until req_done
req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  packed write data, same packing
req_done  out  NUM_REQ  one-cycle completion pulse to the granted requester
req_error  out  1  valid with req_done; 1 = aborted by timeout
rdata  out  DATA_W  read data; valid in the req_done cycle of a read
grant  out  NUM_REQ  one-hot current owner; 0 in IDLE
mem_write_req  out  1  to memory write_req
mem_read_req  out  1  to memory read_req
mem_data_write  out  DATA_W  to memory data_write
mem_addr  out  ADDR_W  to memory addr
mem_data_read  in  DATA_W  from memory data_read
mem_busy  in  1  from memory busy

Behaviour:
- Reset (async, any state): state=IDLE, all outputs 0, last_grant=NUM_REQ-1, timer=0. An in-flight transaction is dropped without a done pulse.
- States: IDLE -> ISSUE -> WAIT_ACCEPT -> WAIT_DONE -> IDLE.
- IDLE: if mem_busy=0 and any (req_write|req_read) is set, pick the first requesting index starting at last_grant+1 (mod NUM_REQ); register grant, last_grant, mem_addr and mem_data_write from that requester; latch op (write if req_write, else read) -> ISSUE. If mem_busy=1 (memory init/flash programming), no arbitration.
- Both req_write and req_read set on the same requester: the write is performed, a single req_done is returned, and the read is not performed.
- ISSUE: mem_write_req or mem_read_req high for exactly this one cycle; timer cleared -> WAIT_ACCEPT.
- WAIT_ACCEPT: mem_busy=1 -> WAIT_DONE. Else timer++; at timer==ACCEPT_TIMEOUT, pulse req_done[grant] with req_error=1, rdata unchanged -> IDLE.
- WAIT_DONE: on mem_busy=0, pulse req_done[grant] with req_error=0; for reads, register rdata<=mem_data_read in the same edge; grant<=0 -> IDLE. No timeout in this state.
- mem_addr and mem_data_write are held from the grant until the next grant and are never changed mid-transaction.
- Minimum latency: request seen in cycle 0 -> ISSUE in cycle 1 -> busy seen at the earliest in cycle 2 -> done pulse at the earliest in cycle 4. At most one outstanding transaction.
- Fairness: with all requesters continuously active, grants rotate 0,1,...,NUM_REQ-1,0. A requester that drops its request before done is still completed. The requester must not re-raise its request in the done cycle expecting a new grant before IDLE.
- rdata holds its last value until the next successful read.

Decomposition:
- Shared package mem_arb_pkg: state enum (IDLE, ISSUE, WAIT_ACCEPT, WAIT_DONE), op encoding (OP_WRITE, OP_READ), default widths ADDR_W/DATA_W matching the memory block.
- One sub-module rr_pick: combinational round-robin priority picker (req vector, last_grant -> one-hot grant, index); reusable by other arbiters.

Test Plan:
- Single write: req 0 writes addr 0x000010, data 0xDEADBEEF; memory model asserts busy for 3 cycles -> one ISSUE cycle with mem_write_req=1 and the stated addr/data; req_done[0] one pulse; req_error=0.
- Read: req 1 reads addr 0x0000AB; model returns 0x12345678 as busy falls -> rdata=0x12345678 in the req_done[1] cycle, held afterwards.
- Contention: both requesters hold write requests for 6 transactions -> grant order 0,1,0,1,0,1; no back-to-back grant to the same requester.
- Busy at idle: mem_busy held high for 50 cycles with req 0 pending -> no mem_*_req until busy drops; then normal completion.
- Timeout: model never raises busy, ACCEPT_TIMEOUT=8 -> req_done pulse with req_error=1 exactly 8 cycles after the WAIT_ACCEPT entry; next request is served normally.
- Reset mid-transaction: assert reset during WAIT_DONE -> outputs 0 immediately without a clock; no req_done; after release, req 1 (last_grant reset) is not favoured over req 0.
